vec_pipe_ctrl: RTL and testbench

Hazard and stall controller for the five-stage SIMD vector pipeline (IF, ID, EX, MEM, WB). It drives the enable and synchronous-clear controls of the four inter-stage pipeline registers. It detects vector-register RAW hazards against in-flight writers, holds EX for multi-cycle vector ops, and flushes on taken branches. It also keeps saturating stall and flush performance counters.

---
 rtl/vec_pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_vec_pipe_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pipe_ctrl.sv
// Hazard and stall controller for the five-stage SIMD vector pipeline.
// It drives the load enables and bubble-clears of the IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. It stalls ID on vector RAW hazards against
// in-flight writers, holds EX for multi-cycle ops, and flushes on taken
// branches. It also keeps saturating stall and flush event counters.
module vec_pipe_ctrl #(
    parameter int REG_ADDR = 4,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic                id_is_multi,
    input  logic                ex_we,
    input  logic                mem_we,
    input  logic                wb_we,
    input  logic [REG_ADDR-1:0] ex_rd,
    input  logic [REG_ADDR-1:0] mem_rd,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                br_taken,
    output logic                en_if_id,
    output logic                en_id_ex,
    output logic                en_ex_mem,
    output logic                en_mem_wb,
    output logic                clr_if_id,
    output logic                clr_id_ex,
    output logic                clr_ex_mem,
    output logic                mul_busy,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count
);

    // The down-counter must be able to hold MUL_LAT itself.
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT);
    // A latency of 1 behaves as an ordinary single-cycle op.
    localparam logic MULTI_EN = (MUL_LAT >= 2);

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic match_rs1;
    logic match_rs2;
    logic raw;
    logic holding;
    logic stall_evt;
    logic flush_evt;
    logic multi_enter;

    // RAW hazard: an ID source register matches any in-flight writer.
    always_comb begin
        match_rs1 = (ex_we  && (ex_rd  == id_rs1)) ||
                    (mem_we && (mem_rd == id_rs1)) ||
                    (wb_we  && (wb_rd  == id_rs1));
        match_rs2 = (ex_we  && (ex_rd  == id_rs2)) ||
                    (mem_we && (mem_rd == id_rs2)) ||
                    (wb_we  && (wb_rd  == id_rs2));
        raw       = id_valid && ((id_rs1_used && match_rs1) ||
                                 (id_rs2_used && match_rs2));
    end

    // The multi op still needs EX for more than the current cycle.
    assign holding = (state_q == MULTI) && (cnt_q > CNT_ONE);

    // Pipe-register controls; the release cycle of MULTI uses the RUN rules.
    always_comb begin
        en_if_id   = 1'b1;
        en_id_ex   = 1'b1;
        en_ex_mem  = 1'b1;
        en_mem_wb  = 1'b1;
        clr_if_id  = 1'b0;
        clr_id_ex  = 1'b0;
        clr_ex_mem = 1'b0;
        mul_busy   = (state_q == MULTI);
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        if (reset) begin
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
            mul_busy  = 1'b0;
        end else if (holding) begin
            // Freeze IF/ID and ID/EX, send bubbles down to MEM.
            en_if_id   = 1'b0;
            en_id_ex   = 1'b0;
            clr_ex_mem = 1'b1;
            stall_evt  = 1'b1;
        end else if (br_taken) begin
            // Flush wins over a hazard: the stalled instruction is squashed anyway.
            clr_if_id = 1'b1;
            clr_id_ex = 1'b1;
            flush_evt = 1'b1;
        end else if (raw) begin
            en_if_id  = 1'b0;
            clr_id_ex = 1'b1;
            stall_evt = 1'b1;
        end
    end

    // A multi op enters EX only when ID/EX really loads the ID instruction.
    assign multi_enter = MULTI_EN && !reset && !holding && id_valid &&
                         id_is_multi && en_id_ex && !clr_id_ex;

    // Next state, occupancy count and saturating event counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (holding) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (multi_enter) begin
            state_d = MULTI;
            cnt_d   = CNT_LOAD;
        end else begin
            state_d = RUN;
            cnt_d   = '0;
        end
        if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_evt && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset abandons any multi op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_vec_pipe_ctrl.sv
// Self-checking bench for vec_pipe_ctrl: directed scenarios plus a
// randomized run against a model that tracks remaining EX occupancy.
module tb_vec_pipe_ctrl;

    localparam int REG_ADDR = 4;
    localparam int MUL_LAT  = 3;
    localparam int CNT_W    = 16;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                id_valid, id_rs1_used, id_rs2_used, id_is_multi;
    logic [REG_ADDR-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic                ex_we, mem_we, wb_we, br_taken;
    logic                en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic                clr_if_id, clr_id_ex, clr_ex_mem, mul_busy;
    logic [CNT_W-1:0]    stall_cycles, flush_count;
    logic [7:0]          obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycles the current multi op still occupies EX (0 = none).
    int         m_left = 0;
    int         m_stalls = 0;
    int         m_flushes = 0;
    logic [7:0] exp_ctrl;
    logic       exp_stall_inc, exp_flush_inc, exp_enter;

    localparam logic [7:0] C_RUN   = 8'b1111_0000;
    localparam logic [7:0] C_RAW   = 8'b0111_0100;
    localparam logic [7:0] C_FLUSH = 8'b1111_1100;
    localparam logic [7:0] C_HOLD  = 8'b0011_0011;
    localparam logic [7:0] C_REL   = 8'b1111_0001;

    vec_pipe_ctrl #(.REG_ADDR(REG_ADDR), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_is_multi(id_is_multi),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .br_taken(br_taken),
        .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
        .en_mem_wb(en_mem_wb), .clr_if_id(clr_if_id), .clr_id_ex(clr_id_ex),
        .clr_ex_mem(clr_ex_mem), .mul_busy(mul_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign obs = {en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                  clr_if_id, clr_id_ex, clr_ex_mem, mul_busy};

    task automatic drive_idle();
        reset = 1'b0; id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_is_multi = 1'b0; id_rs1 = '0; id_rs2 = '0;
        ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0; br_taken = 1'b0;
    endtask

    // Expected controls from the hazard rules applied to the current inputs.
    task automatic model_eval();
        logic            hz;
        logic            we_a[3];
        logic [REG_ADDR-1:0] rd_a[3];
        we_a[0] = ex_we;  we_a[1] = mem_we; we_a[2] = wb_we;
        rd_a[0] = ex_rd;  rd_a[1] = mem_rd; rd_a[2] = wb_rd;
        hz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (we_a[k] && ((id_rs1_used && rd_a[k] == id_rs1) ||
                            (id_rs2_used && rd_a[k] == id_rs2))) hz = 1'b1;
        end
        hz = hz && id_valid;
        exp_stall_inc = 1'b0; exp_flush_inc = 1'b0; exp_enter = 1'b0;
        if (reset) begin
            exp_ctrl = 8'h00;
        end else if (m_left >= 2) begin
            exp_ctrl = C_HOLD;
            exp_stall_inc = 1'b1;
        end else if (br_taken) begin
            exp_ctrl = C_FLUSH | {7'b0, m_left > 0};
            exp_flush_inc = 1'b1;
        end else if (hz) begin
            exp_ctrl = C_RAW | {7'b0, m_left > 0};
            exp_stall_inc = 1'b1;
        end else begin
            exp_ctrl = C_RUN | {7'b0, m_left > 0};
            exp_enter = id_valid && id_is_multi && (MUL_LAT >= 2);
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (exp_stall_inc && m_stalls < CMAX) m_stalls++;
            if (exp_flush_inc && m_flushes < CMAX) m_flushes++;
            if (m_left >= 2) m_left--;
            else if (exp_enter) m_left = MUL_LAT;
            else m_left = 0;
        end
    endtask

    // Let combinational outputs settle well away from the clock edge.
    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        settle();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want %b", obs, 8'h00);
        end
        tick();
        reset = 1'b0;
        settle();
        n_cmp++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
        end
        for (int i = 0; i < 10; i++) begin
            settle();
            n_cmp++;
            if (obs !== C_RUN) begin
                n_bad++; $display("FAIL idle_ctrl[%0d]: got %b want %b", i, obs, C_RUN);
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL idle_cnt: got stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
        end
        $display("test_reset done: stall=%0d flush=%0d", stall_cycles, flush_count);
    endtask

    task automatic test_raw();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            id_valid = 1'b1; id_rs1 = 4'd5; id_rs1_used = 1'b1;
            if (i == 0) begin ex_we = 1'b1;  ex_rd = 4'd5;  end
            if (i == 1) begin mem_we = 1'b1; mem_rd = 4'd5; end
            if (i == 2) begin wb_we = 1'b1;  wb_rd = 4'd5;  end
            settle();
            n_cmp++;
            if (obs !== C_RAW) begin
                n_bad++; $display("FAIL raw_stage%0d: got %b want %b", i, obs, C_RAW);
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 16'd3) begin
            n_bad++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cycles);
        end
        drive_idle();
        id_valid = 1'b1; id_rs1 = 4'd5; id_rs1_used = 1'b1; ex_we = 1'b1; ex_rd = 4'd6;
        settle();
        n_cmp++;
        if (obs !== C_RUN) begin
            n_bad++; $display("FAIL raw_nomatch: got %b want %b", obs, C_RUN);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd3) begin
            n_bad++; $display("FAIL raw_nomatch_cnt: got %0d want 3", stall_cycles);
        end
        $display("test_raw done: stall=%0d", stall_cycles);
    endtask

    task automatic test_branch();
        do_reset();
        drive_idle();
        id_valid = 1'b1; id_rs2 = 4'd9; id_rs2_used = 1'b1; mem_we = 1'b1; mem_rd = 4'd9;
        br_taken = 1'b1;
        settle();
        n_cmp++;
        if (obs !== C_FLUSH) begin
            n_bad++; $display("FAIL branch_ctrl: got %b want %b", obs, C_FLUSH);
        end
        tick();
        n_cmp++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1/0", flush_count, stall_cycles);
        end
        $display("test_branch done: flush=%0d stall=%0d", flush_count, stall_cycles);
    endtask

    task automatic test_multi();
        logic [7:0] want[4];
        want[0] = C_HOLD; want[1] = C_HOLD; want[2] = C_REL; want[3] = C_RUN;
        do_reset();
        drive_idle();
        id_valid = 1'b1; id_is_multi = 1'b1;
        settle();
        n_cmp++;
        if (obs !== C_RUN) begin
            n_bad++; $display("FAIL multi_issue: got %b want %b", obs, C_RUN);
        end
        tick();
        id_is_multi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++;
            if (obs !== want[i]) begin
                n_bad++; $display("FAIL multi_cyc%0d: got %b want %b", i, obs, want[i]);
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 16'd2) begin
            n_bad++; $display("FAIL multi_stall_cnt: got %0d want 2", stall_cycles);
        end
        $display("test_multi done: stall=%0d", stall_cycles);
    endtask

    task automatic test_back_to_back();
        int busy_run;
        do_reset();
        drive_idle();
        id_valid = 1'b1; id_is_multi = 1'b1;
        tick();
        busy_run = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) id_is_multi = 1'b0;
            settle();
            if (mul_busy === 1'b1 && busy_run == i) busy_run++;
            tick();
        end
        n_cmp++;
        if (busy_run !== 6) begin
            n_bad++; $display("FAIL b2b_busy_run: got %0d want 6", busy_run);
        end
        settle();
        n_cmp++;
        if (mul_busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_after: got busy=%b want 0", mul_busy);
        end
        n_cmp++;
        if (stall_cycles !== 16'd4) begin
            n_bad++; $display("FAIL b2b_stall_cnt: got %0d want 4", stall_cycles);
        end
        $display("test_back_to_back done: busy_run=%0d stall=%0d", busy_run, stall_cycles);
    endtask

    task automatic test_reset_mid_multi();
        do_reset();
        drive_idle();
        id_valid = 1'b1; id_is_multi = 1'b1; br_taken = 1'b1;
        tick();
        id_is_multi = 1'b1; br_taken = 1'b0;
        tick();
        tick();
        drive_idle();
        id_valid = 1'b1; id_is_multi = 1'b1;
        tick();
        reset = 1'b1;
        settle();
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++; $display("FAIL midmulti_reset_ctrl: got %b want %b", obs, 8'h00);
        end
        tick();
        drive_idle();
        settle();
        n_cmp++;
        if (mul_busy !== 1'b0 || stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midmulti_after: got busy=%b stall=%0d flush=%0d want 0/0/0",
                     mul_busy, stall_cycles, flush_count);
        end
        n_cmp++;
        if (obs !== C_RUN) begin
            n_bad++; $display("FAIL midmulti_run: got %b want %b", obs, C_RUN);
        end
        tick();
        $display("test_reset_mid_multi done: busy=%b", mul_busy);
    endtask

    task automatic test_random();
        int bad0;
        bad0 = n_bad;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_idle();
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rs1      = REG_ADDR'($urandom_range(0, 3));
            id_rs2      = REG_ADDR'($urandom_range(0, 3));
            id_rs1_used = $urandom_range(0, 1) == 1;
            id_rs2_used = $urandom_range(0, 1) == 1;
            id_is_multi = ($urandom_range(0, 4) == 0);
            ex_we  = ($urandom_range(0, 2) == 0); ex_rd  = REG_ADDR'($urandom_range(0, 7));
            mem_we = ($urandom_range(0, 2) == 0); mem_rd = REG_ADDR'($urandom_range(0, 7));
            wb_we  = ($urandom_range(0, 2) == 0); wb_rd  = REG_ADDR'($urandom_range(0, 7));
            br_taken = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            settle();
            n_cmp++;
            if (obs !== exp_ctrl) begin
                n_bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, obs, exp_ctrl);
            end
            tick();
            n_cmp++;
            if (stall_cycles !== CNT_W'(m_stalls) || flush_count !== CNT_W'(m_flushes)) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: got stall=%0d flush=%0d want %0d/%0d",
                         i, stall_cycles, flush_count, m_stalls, m_flushes);
            end
        end
        $display("test_random done: new_fail=%0d stall=%0d flush=%0d",
                 n_bad - bad0, m_stalls, m_flushes);
    endtask

    task automatic test_saturation();
        do_reset();
        drive_idle();
        id_valid = 1'b1; id_rs1 = 4'd2; id_rs1_used = 1'b1; wb_we = 1'b1; wb_rd = 4'd2;
        for (int i = 0; i < CMAX + 4; i++) tick();
        n_cmp++;
        if (stall_cycles !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_reach: got %h want FFFF", stall_cycles);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (stall_cycles !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_hold: got %h want FFFF", stall_cycles);
        end
        $display("test_saturation done: stall=%h", stall_cycles);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_raw();
        test_branch();
        test_multi();
        test_back_to_back();
        test_reset_mid_multi();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
